// File: rtl/uart_rom_loader_pkg.sv
// Shared types and constants for the UART boot loader that fills the core's instruction ROM.
package uart_rom_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        L_SYNC,
        L_COUNT,
        L_DATA,
        L_DONE
    } load_state_t;

    function automatic logic is_sync(input logic [7:0] b);
        return b == SYNC_BYTE;
    endfunction

endpackage

// File: rtl/uart_rom_loader_if.sv
// Serial input plus ROM write port and core-release status of the boot loader.
interface uart_rom_loader_if #(
    parameter int ADDR_W = 8
);
    logic              uart_rx;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              frame_err;

    modport master (
        input  uart_rx,
        output rom_we, rom_waddr, rom_wdata, core_rst_n, busy, frame_err
    );

    modport slave (
        output uart_rx,
        input  rom_we, rom_waddr, rom_wdata, core_rst_n, busy, frame_err
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises the line, rejects start glitches, flags bad stop bits.
module uart_rx_byte
    import uart_rom_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic       o_byte_err,
    output logic [7:0] o_byte_data
);
    localparam int HALF  = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    logic             r_rx_meta;
    logic             r_rx_sync;
    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             w_cnt_full;
    logic             w_cnt_half;

    assign w_cnt_full  = (r_cnt == CNT_FULL);
    assign w_cnt_half  = (r_cnt == CNT_HALF);
    assign o_byte_data = r_shift;

    // Idle level is high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= R_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_byte_valid = 1'b0;
        o_byte_err   = 1'b0;
        case (r_state)
            R_IDLE:  if (!r_rx_sync) w_next = R_START;
            R_START: if (w_cnt_half) w_next = r_rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (w_cnt_full && r_bit_idx == 3'd7) w_next = R_STOP;
            R_STOP: begin
                if (w_cnt_full) begin
                    w_next       = R_IDLE;
                    o_byte_valid = r_rx_sync;
                    o_byte_err   = !r_rx_sync;
                end
            end
            default: w_next = R_IDLE;
        endcase
    end

    // The start-bit half period aligns every later sample to mid-bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            case (r_state)
                R_START: r_cnt <= w_cnt_half ? '0 : r_cnt + CNT_W'(1);
                R_DATA: begin
                    if (w_cnt_full) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                R_STOP:  r_cnt <= w_cnt_full ? '0 : r_cnt + CNT_W'(1);
                default: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_rom_loader.sv
// Boot loader: assembles UART bytes into little-endian words, writes them to ROM, releases the core.
module uart_rom_loader
    import uart_rom_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8
) (
    input  logic clk,
    input  logic rst,
    uart_rom_loader_if.master bus
);
    logic              w_byte_valid;
    logic              w_byte_err;
    logic [7:0]        w_byte_data;
    load_state_t       r_state;
    load_state_t       w_next;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [ADDR_W-1:0] r_n;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_asm;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_core_rst_n;
    logic              r_frame_err;
    logic              w_sync;
    logic              w_last_byte;
    logic              w_last_word;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (bus.uart_rx),
        .o_byte_valid (w_byte_valid),
        .o_byte_err   (w_byte_err),
        .o_byte_data  (w_byte_data)
    );

    assign w_sync      = w_byte_valid && is_sync(w_byte_data);
    assign w_last_byte = (r_byte_idx == 2'd3);
    // N = 0 means a full 2^ADDR_W image: the wrapped counter then matches 0 on the last word.
    assign w_last_word = ((r_word_cnt + ADDR_W'(1)) == r_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= L_SYNC;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            L_SYNC: if (w_sync) w_next = L_COUNT;
            L_COUNT: begin
                if (w_byte_err)        w_next = L_SYNC;
                else if (w_byte_valid) w_next = L_DATA;
            end
            L_DATA: begin
                if (w_byte_err) w_next = L_SYNC;
                else if (w_byte_valid && w_last_byte && w_last_word) w_next = L_DONE;
            end
            L_DONE: if (w_sync) w_next = L_COUNT;
            default: w_next = L_SYNC;
        endcase
    end

    // Core release lags entry to L_DONE by a cycle so the final write lands first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt   <= '0;
            r_n          <= '0;
            r_byte_idx   <= 2'd0;
            r_asm        <= 24'd0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= 32'd0;
            r_core_rst_n <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_core_rst_n <= (r_state == L_DONE) && (w_next == L_DONE);
            if (w_byte_err) begin
                r_frame_err <= 1'b1;
                if (r_state == L_COUNT || r_state == L_DATA) begin
                    r_word_cnt <= '0;
                    r_byte_idx <= 2'd0;
                end
            end else if (w_byte_valid) begin
                case (r_state)
                    L_SYNC: begin
                        if (w_sync) begin
                            r_frame_err <= 1'b0;
                            r_word_cnt  <= '0;
                            r_byte_idx  <= 2'd0;
                        end
                    end
                    L_COUNT: r_n <= ADDR_W'(w_byte_data);
                    L_DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= w_byte_data;
                            2'd1: r_asm[15:8]  <= w_byte_data;
                            2'd2: r_asm[23:16] <= w_byte_data;
                            default: begin
                                r_we       <= 1'b1;
                                r_waddr    <= r_word_cnt;
                                r_wdata    <= {w_byte_data, r_asm};
                                r_word_cnt <= r_word_cnt + ADDR_W'(1);
                            end
                        endcase
                    end
                    L_DONE: begin
                        if (w_sync) begin
                            r_word_cnt <= '0;
                            r_byte_idx <= 2'd0;
                        end
                    end
                    default: r_byte_idx <= 2'd0;
                endcase
            end
        end
    end

    assign bus.rom_we     = r_we;
    assign bus.rom_waddr  = r_waddr;
    assign bus.rom_wdata  = r_wdata;
    assign bus.core_rst_n = r_core_rst_n;
    assign bus.busy       = (r_state == L_COUNT) || (r_state == L_DATA);
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader: serialises images and scoreboards every ROM write.
module tb_uart_rom_loader;
    import uart_rom_loader_pkg::*;

    localparam int CPB    = 4;
    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wr_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   writeCount = 0;
    int   expWrites = 0;
    logic prevWe = 1'b0;
    logic prevCoreRstN = 1'b0;

    always #5 clk = ~clk;

    uart_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_rom_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Every write is popped from the scoreboard; core release must directly follow a write.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rom_we) begin
                writeCount++;
                checkOutput("we_one_cycle", {31'd0, prevWe}, 32'd0);
                checkOutput("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    checkOutput("waddr", {24'd0, bus.rom_waddr}, {24'd0, e.addr});
                    checkOutput("wdata", bus.rom_wdata, e.data);
                end
            end
            if (bus.core_rst_n && !prevCoreRstN)
                checkOutput("rst_n_after_we", {31'd0, prevWe}, 32'd1);
        end
        prevWe       <= bus.rom_we;
        prevCoreRstN <= bus.core_rst_n;
    end

    task automatic holdBit(input logic v);
        bus.uart_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit badStop);
        holdBit(1'b0);
        for (int i = 0; i < 8; i++) holdBit(b[i]);
        holdBit(!badStop);
        holdBit(1'b1);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], 1'b0);
    endtask

    task automatic expectWrite(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
        expWrites++;
    endtask

    task automatic sendTwoWordImage();
        expectWrite(8'd0, 32'h0000_0013);
        expectWrite(8'd1, 32'h0010_0093);
        applyStimulus(SYNC_BYTE, 1'b0);
        applyStimulus(8'h02, 1'b0);
        sendWord(32'h0000_0013);
        sendWord(32'h0010_0093);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, sb.size(), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_we"}, {31'd0, bus.rom_we}, 32'd0);
        checkOutput({tag, "_waddr"}, {24'd0, bus.rom_waddr}, 32'd0);
        checkOutput({tag, "_wdata"}, bus.rom_wdata, 32'd0);
        checkOutput({tag, "_core_rst_n"}, {31'd0, bus.core_rst_n}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.uart_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;

        $display("[TB] idle line after reset");
        repeat (20 * CPB * 10) @(negedge clk);
        checkOutput("idle_core_rst_n", {31'd0, bus.core_rst_n}, 32'd0);
        checkOutput("idle_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("idle_writes", writeCount, expWrites);

        $display("[TB] two-word load");
        expectWrite(8'd0, 32'h0000_0013);
        expectWrite(8'd1, 32'h0010_0093);
        applyStimulus(SYNC_BYTE, 1'b0);
        applyStimulus(8'h02, 1'b0);
        checkOutput("busy_loading", {31'd0, bus.busy}, 32'd1);
        sendWord(32'h0000_0013);
        sendWord(32'h0010_0093);
        waitDrain("two_word_drain");
        checkOutput("two_word_core_rst_n", {31'd0, bus.core_rst_n}, 32'd1);
        checkOutput("two_word_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("hold_waddr", {24'd0, bus.rom_waddr}, 32'd1);
        checkOutput("hold_wdata", bus.rom_wdata, 32'h0010_0093);
        checkOutput("two_word_writes", writeCount, expWrites);

        $display("[TB] garbage before sync");
        doReset();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h5A, 1'b0);
        checkOutput("garbage_busy", {31'd0, bus.busy}, 32'd0);
        sendTwoWordImage();
        waitDrain("garbage_drain");
        checkOutput("garbage_core_rst_n", {31'd0, bus.core_rst_n}, 32'd1);
        checkOutput("garbage_writes", writeCount, expWrites);

        $display("[TB] framing error mid-load");
        doReset();
        applyStimulus(SYNC_BYTE, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h13, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("ferr_set", {31'd0, bus.frame_err}, 32'd1);
        checkOutput("ferr_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("ferr_core_rst_n", {31'd0, bus.core_rst_n}, 32'd0);
        checkOutput("ferr_writes", writeCount, expWrites);
        expectWrite(8'd0, 32'h0000_0013);
        expectWrite(8'd1, 32'h0010_0093);
        applyStimulus(SYNC_BYTE, 1'b0);
        checkOutput("ferr_cleared", {31'd0, bus.frame_err}, 32'd0);
        applyStimulus(8'h02, 1'b0);
        sendWord(32'h0000_0013);
        sendWord(32'h0010_0093);
        waitDrain("ferr_drain");
        checkOutput("ferr_reload_core_rst_n", {31'd0, bus.core_rst_n}, 32'd1);

        $display("[TB] full 256-word image");
        doReset();
        for (int i = 0; i < 256; i++) expectWrite(8'(i), 32'(i));
        applyStimulus(SYNC_BYTE, 1'b0);
        applyStimulus(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) sendWord(32'(i));
        waitDrain("full_drain");
        checkOutput("full_core_rst_n", {31'd0, bus.core_rst_n}, 32'd1);
        checkOutput("full_last_addr", {24'd0, bus.rom_waddr}, 32'd255);
        checkOutput("full_writes", writeCount, expWrites);
        applyStimulus(SYNC_BYTE, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reload_core_rst_n", {31'd0, bus.core_rst_n}, 32'd0);
        checkOutput("reload_busy", {31'd0, bus.busy}, 32'd1);

        $display("[TB] start-bit glitch");
        doReset();
        applyStimulus(SYNC_BYTE, 1'b0);
        bus.uart_rx = 1'b0;
        @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        expectWrite(8'd0, 32'h4433_2211);
        applyStimulus(8'h01, 1'b0);
        sendWord(32'h4433_2211);
        waitDrain("glitch_drain");
        checkOutput("glitch_core_rst_n", {31'd0, bus.core_rst_n}, 32'd1);
        checkOutput("glitch_writes", writeCount, expWrites);

        $display("[TB] reset mid-word");
        applyStimulus(SYNC_BYTE, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        rst = 1'b1;
        #1;
        checkResetValues("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("midrst_writes", writeCount, expWrites);
        checkOutput("midrst_core_rst_n", {31'd0, bus.core_rst_n}, 32'd0);
        checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);

        checkOutput("sb_empty_end", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rom_loader.md
# uart_rom_loader

Boot-time program loader sitting directly upstream of the single-cycle RISC-V core's instruction ROM. It receives a program image over a UART receive line and assembles little-endian 32-bit instruction words. Each word is written into the ROM's write port at consecutive word addresses matching the core's 8-bit `rom_addr` space. The core is held in reset until a complete image has been loaded, then released.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per UART bit (100 MHz / 115200 baud).
- `ADDR_W`, default 8: ROM word-address width; one image holds up to 2^ADDR_W words.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, asynchronous and active-high.
- `uart_rx`  in  1  serial input, 8N1, idle high, asynchronous to `clk`.
- `rom_we`  out  1  one-cycle ROM write strobe.
- `rom_waddr`  out  ADDR_W  ROM word address.
- `rom_wdata`  out  32  instruction word.
- `core_rst_n`  out  1  core reset, active-low; low until a load completes.
- `busy`  out  1  high while an image is being received.
- `frame_err`  out  1  sticky framing-error flag.

## Operation
- `uart_rx` passes through a 2-flop synchroniser before any use.
- **RX FSM** states are R_IDLE, R_START, R_DATA and R_STOP.
  - R_IDLE → R_START on a low level.
  - R_START waits CLKS_PER_BIT/2 cycles, then re-samples the line. If it is high, the start bit was a glitch: return to R_IDLE and emit no byte. If it is low, go to R_DATA.
  - R_DATA samples 8 bits, LSB first, one every CLKS_PER_BIT cycles.
  - R_STOP samples once more after CLKS_PER_BIT cycles. If the sample is 1, pulse `byte_valid` for one cycle. If it is 0, pulse `byte_err` for one cycle and discard the byte. Both cases return to R_IDLE.
- **Load FSM** states are L_SYNC, L_COUNT, L_DATA and L_DONE.
  - L_SYNC ignores every byte except 0xA5. On 0xA5 it clears `frame_err` and the word counter, then goes to L_COUNT.
  - L_COUNT latches N from the next byte; a value of 0 means 2^ADDR_W words. Go to L_DATA.
  - L_DATA places byte k (k = 0..3) into `rom_wdata[8k+7:8k]`. On byte 3, pulse `rom_we` with `rom_waddr` set to the word counter, then increment the counter (ADDR_W-bit, wraps). After N words, go to L_DONE.
  - L_DONE drives `core_rst_n` = 1. Receiving 0xA5 here drops `core_rst_n` to 0 and re-enters L_COUNT (reload). All other bytes are ignored.
- `byte_err` in L_COUNT or L_DATA: set `frame_err`, abort to L_SYNC, clear the word counter, keep `core_rst_n` = 0. Words already written stay in ROM.
- `byte_err` in L_SYNC or L_DONE: set `frame_err` only.
- `busy` = 1 in L_COUNT and L_DATA only.

## Timing
- Reset values: `rom_we` 0, `rom_waddr` 0, `rom_wdata` 0, `core_rst_n` 0, `busy` 0, `frame_err` 0. Both FSMs go to their idle states (R_IDLE, L_SYNC), and the word and byte counters clear.
- Reset asserted mid-operation returns the block to the reset values immediately; no further writes occur.
- `byte_valid` occurs at the stop-bit sample, ≈9.5·CLKS_PER_BIT cycles after the synchronised falling edge of the start bit.
- `rom_we` rises on the cycle after the `byte_valid` of byte 3. `rom_waddr` and `rom_wdata` are stable while `rom_we` is high and hold their values until the next write.
- `core_rst_n` rises on the cycle after the last `rom_we`. That write has therefore completed before the core leaves reset.
- `byte_valid` and `byte_err` are mutually exclusive. At most one byte event occurs per cycle, so no simultaneous-event arbitration is needed.

## Structure
- Package `uart_rom_loader_pkg`:
  - `SYNC_BYTE` = 8'hA5.
  - RX-state enum and load-state enum.
- Sub-module `uart_rx_byte`:
  - Contains the synchroniser and the RX FSM.
  - Outputs `byte_valid`, `byte_err` and an 8-bit `byte_data`.
  - The parent contains the load FSM, the word assembler and the outputs.

## Test plan
- **Idle after reset.** Reset released, `uart_rx` held high for 20 bit times → `core_rst_n` = 0, `busy` = 0, and `rom_we` never pulses.
- **Two-word load.** Send A5, 02, 13 00 00 00, 93 00 10 00 → two writes: addr 0 = 0x00000013, then addr 1 = 0x00100093. `core_rst_n` rises one cycle after the second `rom_we`.
- **Garbage before sync.** Send 00, FF, 5A, then the two-word image → the leading bytes are ignored and the writes are identical to the previous scenario.
- **Framing error mid-load.** Send A5, 02, 13 00, then a byte whose stop bit is forced to 0 → `frame_err` = 1, no write occurs, `core_rst_n` stays 0. A subsequent valid image clears `frame_err` at A5 and loads correctly.
- **Full image.** Send A5, 00, then 1024 bytes → 256 writes at addresses 0..255, each word equal to its index. `core_rst_n` rises after addr 255. A further A5 drops `core_rst_n` to 0.
- **Glitch and reset.** A low pulse shorter than CLKS_PER_BIT/2 → no byte event. Assert `rst` after byte 2 of a word → all outputs return to reset values with no write.
